eb_rr_arb: RTL and testbench

EB_RR_ARB -- requirements
Module: eb_rr_arb

---
 rtl/eb_rr_arb.sv | 110 +++++++++++
 tb/tb_eb_rr_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eb_rr_arb.sv
// Round-robin packet arbiter: N requester streams merged into one registered output stream.
// Once a packet starts, its source holds the output until the beat carrying t_last is taken.
module eb_rr_arb #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SW    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] t_data,
   input  logic [N-1:0]       t_valid,
   input  logic [N-1:0]       t_last,
   output logic [N-1:0]       t_ready,
   output logic [WIDTH-1:0]   i0_data,
   output logic               i0_last,
   output logic [SW-1:0]      i0_sel,
   output logic               i0_valid,
   input  logic               i0_ready,
   output logic               dbg_lock,
   output logic [SW-1:0]      dbg_ptr,
   output logic [SW-1:0]      dbg_lk
);

   // Handshake: a beat moves on any edge where valid and ready are both high; valid never
   // waits for ready, and ready here is a function of t_valid, i0_ready and state only.

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] lk_q, lk_d;
   logic [SW-1:0] sel_rr, sel;
   logic          found_rr, have, xfer, load;
   int            j;

   assign load = ~i0_valid | i0_ready;

   // First valid requester at or after ptr, wrapping modulo N.
   always_comb begin
      found_rr = 1'b0;
      sel_rr   = '0;
      j        = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         if (!found_rr && t_valid[j]) begin
            found_rr = 1'b1;
            sel_rr   = SW'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lk_d    = lk_q;
      sel     = sel_rr;
      have    = found_rr;
      t_ready = '0;
      if (state_q == LOCK) begin
         sel  = lk_q;
         have = t_valid[lk_q];
      end
      xfer = load & have & ~reset;
      for (int k = 0; k < N; k++) begin
         if (xfer && (sel == SW'(k))) t_ready[k] = 1'b1;
      end
      if (xfer) begin
         if (t_last[sel]) begin
            state_d = IDLE;
            ptr_d   = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
         end else begin
            state_d = LOCK;
            lk_d    = sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         lk_q     <= '0;
         i0_valid <= 1'b0;
         i0_data  <= '0;
         i0_last  <= 1'b0;
         i0_sel   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lk_q    <= lk_d;
         if (load) begin
            i0_valid <= xfer;
            if (xfer) begin
               i0_data <= t_data[int'(sel)*WIDTH +: WIDTH];
               i0_last <= t_last[sel];
               i0_sel  <= sel;
            end
         end
      end
   end

   assign dbg_lock = (state_q == LOCK);
   assign dbg_ptr  = ptr_q;
   assign dbg_lk   = lk_q;

endmodule

// File: tb/tb_eb_rr_arb.sv
// Bench for eb_rr_arb: requester packet buffers, a round-robin/lock reference model,
// and a scoreboard that checks every beat leaving on i0.
module tb_eb_rr_arb;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SW    = 2;
   localparam int EW    = SW + 1 + WIDTH;
   localparam int DEPTH = 256;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [N*WIDTH-1:0] t_data = '0;
   logic [N-1:0]       t_valid = '0;
   logic [N-1:0]       t_last = '0;
   logic [N-1:0]       t_ready;
   logic [WIDTH-1:0]   i0_data;
   logic               i0_last;
   logic [SW-1:0]      i0_sel;
   logic               i0_valid;
   logic               i0_ready = 1'b0;
   logic               dbg_lock;
   logic [SW-1:0]      dbg_ptr;
   logic [SW-1:0]      dbg_lk;

   eb_rr_arb #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
      .clk(clk), .reset(reset),
      .t_data(t_data), .t_valid(t_valid), .t_last(t_last), .t_ready(t_ready),
      .i0_data(i0_data), .i0_last(i0_last), .i0_sel(i0_sel),
      .i0_valid(i0_valid), .i0_ready(i0_ready),
      .dbg_lock(dbg_lock), .dbg_ptr(dbg_ptr), .dbg_lk(dbg_lk)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0]    exp_q[$];
   logic [WIDTH:0]   rbuf [N][DEPTH];
   int               rhead [N];
   int               rtail [N];

   // reference model state
   logic m_ov   = 1'b0;
   logic m_lock = 1'b0;
   int   m_ptr  = 0;
   int   m_lk   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_beat(input int k, input logic last, input logic [WIDTH-1:0] d);
      rbuf[k][rtail[k] % DEPTH] = {last, d};
      rtail[k]++;
   endtask

   task automatic add_pkt(input int k, input int len);
      for (int b = 0; b < len; b++) add_beat(k, (b == len - 1), WIDTH'($urandom));
   endtask

   // One clock cycle; entered and left at posedge+1.
   task automatic cycle(input logic [N-1:0] vmask, input logic rdy);
      logic [N-1:0] tv;
      logic [N-1:0] exp_rdy;
      logic [WIDTH:0] beat;
      logic ld;
      int g;
      check("i0_valid", 32'(i0_valid), 32'(m_ov));
      check("lock", 32'(dbg_lock), 32'(m_lock));
      check("ptr", 32'(dbg_ptr), 32'(m_ptr));
      if (m_lock) check("lk", 32'(dbg_lk), 32'(m_lk));
      for (int k = 0; k < N; k++) begin
         if (rhead[k] != rtail[k]) begin
            tv[k] = vmask[k];
            t_data[k*WIDTH +: WIDTH] = rbuf[k][rhead[k] % DEPTH][WIDTH-1:0];
            t_last[k] = rbuf[k][rhead[k] % DEPTH][WIDTH];
         end else begin
            tv[k] = 1'b0;
            t_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            t_last[k] = 1'($urandom);
         end
      end
      t_valid  = tv;
      i0_ready = rdy;
      #1;
      ld = !m_ov || rdy;
      g  = -1;
      if (ld) begin
         if (m_lock) begin
            if (tv[m_lk]) g = m_lk;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (g < 0 && tv[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("t_ready", 32'(t_ready), 32'(exp_rdy));
      if (g >= 0) begin
         beat = rbuf[g][rhead[g] % DEPTH];
         rhead[g]++;
         exp_q.push_back({SW'(g), beat});
         if (beat[WIDTH]) begin
            m_lock = 1'b0;
            m_ptr  = (g + 1) % N;
         end else begin
            m_lock = 1'b1;
            m_lk   = g;
         end
         m_ov = 1'b1;
      end else if (ld) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      i0_ready = 1'b0;
      t_valid  = N'($urandom);
      t_data   = (N*WIDTH)'({$urandom, $urandom});
      t_last   = N'($urandom);
      #1;
      check("t_ready_in_reset", 32'(t_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_i0_valid", 32'(i0_valid), 32'd0);
      check("rst_i0_data", 32'(i0_data), 32'd0);
      check("rst_i0_last", 32'(i0_last), 32'd0);
      check("rst_i0_sel", 32'(i0_sel), 32'd0);
      check("rst_lock", 32'(dbg_lock), 32'd0);
      check("rst_ptr", 32'(dbg_ptr), 32'd0);
      exp_q.delete();
      m_ov   = 1'b0;
      m_lock = 1'b0;
      m_ptr  = 0;
      m_lk   = 0;
   endtask

   // Monitor: a beat is consumed on the coming edge when both sides of i0 are high.
   always @(negedge clk) begin
      if (!reset && i0_valid === 1'b1 && i0_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat: got sel=%0d data=%0h with nothing expected at %0t", i0_sel, i0_data, $time);
         end else begin
            check("beat", 32'({i0_sel, i0_last, i0_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         rhead[k] = 0;
         rtail[k] = 0;
      end
      @(posedge clk);
      #1;
      do_reset();

      // all requesters busy, single-beat packets: sel 0,1,2,3,0,...
      for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) add_pkt(k, 1);
      repeat (9) cycle(4'b1111, 1'b1);

      // 3-beat packet from requester 2 stays contiguous while requester 0 waits
      add_beat(2, 1'b0, 8'hA0);
      add_beat(2, 1'b0, 8'hA1);
      add_beat(2, 1'b1, 8'hA2);
      add_pkt(0, 1);
      cycle(4'b0100, 1'b1);
      repeat (4) cycle(4'b0101, 1'b1);

      // output back-pressure holds everything
      add_pkt(1, 2);
      cycle(4'b0010, 1'b1);
      repeat (3) cycle(4'b0010, 1'b0);
      repeat (3) cycle(4'b0010, 1'b1);

      // lock on 3 survives a gap in t_valid[3] while 1 is waiting
      add_pkt(3, 3);
      add_pkt(1, 1);
      cycle(4'b1000, 1'b1);
      repeat (2) cycle(4'b0010, 1'b1);
      repeat (4) cycle(4'b1010, 1'b1);

      // pointer wrap after requester 3, then 0 wins over 3
      add_pkt(3, 1);
      cycle(4'b1000, 1'b1);
      add_pkt(0, 1);
      add_pkt(3, 1);
      repeat (3) cycle(4'b1001, 1'b1);

      // reset in the middle of a packet with a beat held on the output
      add_pkt(2, 3);
      repeat (2) cycle(4'b0100, 1'b1);
      do_reset();
      add_pkt(1, 1);
      repeat (2) cycle(4'b0010, 1'b1);

      // randomized traffic
      repeat (1500) begin
         for (int k = 0; k < N; k++) begin
            if ((rtail[k] - rhead[k]) < 8 && $urandom_range(0, 3) == 0) add_pkt(k, $urandom_range(1, 4));
         end
         cycle(N'($urandom), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      repeat (60) cycle(4'b1111, 1'b1);
      repeat (4) cycle(4'b0000, 1'b1);
      check("drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
